// File: rtl/multi_tick_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
// Build option MULTI_TICK_OVR_CNT_EN adds the per-channel saturating overrun counters.
package multi_tick_pkg;

    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_TOGGLE = 1'b1
    } mode_t;

    localparam int MAX_CH = 16;

    // Channel-select width; never below one bit so a single-channel build still has a port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_tick_chan.sv
// One tick channel: free-running period counter, runtime config registers and REQ/ACK tracking.
// With MULTI_TICK_OVR_CNT_EN defined it also keeps a saturating overrun count.
module multi_tick_chan
    import multi_tick_pkg::*;
#(
    parameter int          CNT_W      = 29,
    parameter int unsigned DEFAULT_TC = 4999999,
    parameter bit          DEFAULT_EN = 1'b1,
    parameter bit          DEFAULT_MD = 1'b1
`ifdef MULTI_TICK_OVR_CNT_EN
    ,
    parameter int          OVR_W      = 8
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_tc,
    input  logic             cfg_mode,
    input  logic             cfg_en,
    input  logic             ack,
    output logic             tick,
    output logic             wave,
    output logic             req,
    output logic             overrun
`ifdef MULTI_TICK_OVR_CNT_EN
    ,
    output logic [OVR_W-1:0] ovr_cnt
`endif
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] tc_q;
    logic             en_q;
    mode_t            mode_q;
    logic             tick_q;
    logic             wave_q;
    logic             req_q;
    logic             overrun_q;
`ifdef MULTI_TICK_OVR_CNT_EN
    logic [OVR_W-1:0] ovr_cnt_q;
`endif

    logic wrap;
    logic tick_ev;

    assign wrap    = (cnt_q == tc_q);
    assign tick_ev = en_q && wrap;

    // Handshake: REQ rises on the tick edge and stays high until an edge sees ACK=1
    // with REQ=1; ACK while REQ=0 is ignored. A tick arriving on the same edge as
    // the ACK re-arms REQ (old request consumed), a tick without ACK is an overrun.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q     <= '0;
            tc_q      <= CNT_W'(DEFAULT_TC);
            en_q      <= DEFAULT_EN;
            mode_q    <= mode_t'(DEFAULT_MD);
            tick_q    <= 1'b0;
            wave_q    <= 1'b0;
            req_q     <= 1'b0;
            overrun_q <= 1'b0;
`ifdef MULTI_TICK_OVR_CNT_EN
            ovr_cnt_q <= '0;
`endif
        end else if (cfg_we) begin
            cnt_q     <= '0;
            tc_q      <= cfg_tc;
            en_q      <= cfg_en;
            mode_q    <= mode_t'(cfg_mode);
            tick_q    <= 1'b0;
            wave_q    <= 1'b0;
            req_q     <= 1'b0;
            overrun_q <= 1'b0;
`ifdef MULTI_TICK_OVR_CNT_EN
            ovr_cnt_q <= '0;
`endif
        end else begin
            if (en_q) begin
                cnt_q  <= wrap ? '0 : cnt_q + CNT_W'(1);
                tick_q <= wrap;
                if (mode_q == MODE_TOGGLE) begin
                    if (wrap) begin
                        wave_q <= ~wave_q;
                    end
                end else begin
                    wave_q <= wrap;
                end
            end else begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end

            if (tick_ev) begin
                req_q <= 1'b1;
            end else if (ack && req_q) begin
                req_q <= 1'b0;
            end

            if (tick_ev && req_q && !ack) begin
                overrun_q <= 1'b1;
`ifdef MULTI_TICK_OVR_CNT_EN
                if (ovr_cnt_q != '1) begin
                    ovr_cnt_q <= ovr_cnt_q + OVR_W'(1);
                end
`endif
            end
        end
    end

    assign tick    = tick_q;
    assign wave    = wave_q;
    assign req     = req_q;
    assign overrun = overrun_q;
`ifdef MULTI_TICK_OVR_CNT_EN
    assign ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable periodic tick generator with per-channel REQ/ACK hand-off.
// Build option MULTI_TICK_OVR_CNT_EN adds the OVR_CNT port with saturating overrun counters.
module multi_tick_gen
    import multi_tick_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 29,
    parameter int unsigned DEFAULT_TC = 4999999,
    parameter bit          DEFAULT_EN = 1'b1,
    parameter bit          DEFAULT_MD = 1'b1,
`ifdef MULTI_TICK_OVR_CNT_EN
    parameter int          OVR_W      = 8,
`endif
    localparam int         CH_W       = clog2_min1(NUM_CH)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CFG_WE,
    input  logic [CH_W-1:0]         CFG_CH,
    input  logic [CNT_W-1:0]        CFG_TC,
    input  logic                    CFG_MODE,
    input  logic                    CFG_EN,
    output logic [NUM_CH-1:0]       TICK,
    output logic [NUM_CH-1:0]       WAVE,
    output logic [NUM_CH-1:0]       REQ,
    input  logic [NUM_CH-1:0]       ACK,
    output logic [NUM_CH-1:0]       OVERRUN
`ifdef MULTI_TICK_OVR_CNT_EN
    ,
    output logic [NUM_CH*OVR_W-1:0] OVR_CNT
`endif
);

    logic [NUM_CH-1:0] ch_we;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range CFG_CH values match no channel, so such writes fall on the floor.
        assign ch_we[i] = CFG_WE && (CFG_CH == CH_W'(i));

        multi_tick_chan #(
            .CNT_W      (CNT_W),
            .DEFAULT_TC (DEFAULT_TC),
            .DEFAULT_EN (DEFAULT_EN),
            .DEFAULT_MD (DEFAULT_MD)
`ifdef MULTI_TICK_OVR_CNT_EN
            ,
            .OVR_W      (OVR_W)
`endif
        ) u_chan (
            .CLK      (CLK),
            .RESET    (RESET),
            .cfg_we   (ch_we[i]),
            .cfg_tc   (CFG_TC),
            .cfg_mode (CFG_MODE),
            .cfg_en   (CFG_EN),
            .ack      (ACK[i]),
            .tick     (TICK[i]),
            .wave     (WAVE[i]),
            .req      (REQ[i]),
            .overrun  (OVERRUN[i])
`ifdef MULTI_TICK_OVR_CNT_EN
            ,
            .ovr_cnt  (OVR_CNT[i*OVR_W +: OVR_W])
`endif
        );
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Bench for multi_tick_gen: directed scenarios plus random traffic against a tick-time model.
// Honours MULTI_TICK_OVR_CNT_EN the same way the design does.
module tb_multi_tick_gen;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 29;
    localparam int DEF_TC = 19;
    localparam int CH_W   = 3;
    localparam int OVR_W  = 8;

    // clock / reset
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                    RESET;
    logic                    CFG_WE;
    logic [CH_W-1:0]         CFG_CH;
    logic [CNT_W-1:0]        CFG_TC;
    logic                    CFG_MODE;
    logic                    CFG_EN;
    logic [NUM_CH-1:0]       TICK;
    logic [NUM_CH-1:0]       WAVE;
    logic [NUM_CH-1:0]       REQ;
    logic [NUM_CH-1:0]       ACK;
    logic [NUM_CH-1:0]       OVERRUN;
`ifdef MULTI_TICK_OVR_CNT_EN
    logic [NUM_CH*OVR_W-1:0] OVR_CNT;
`endif

    multi_tick_gen #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEFAULT_TC (DEF_TC),
        .DEFAULT_EN (1'b1),
        .DEFAULT_MD (1'b1)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CFG_WE   (CFG_WE),
        .CFG_CH   (CFG_CH),
        .CFG_TC   (CFG_TC),
        .CFG_MODE (CFG_MODE),
        .CFG_EN   (CFG_EN),
        .TICK     (TICK),
        .WAVE     (WAVE),
        .REQ      (REQ),
        .ACK      (ACK),
        .OVERRUN  (OVERRUN)
`ifdef MULTI_TICK_OVR_CNT_EN
        ,
        .OVR_CNT  (OVR_CNT)
`endif
    );

    // reference model: a channel ticks on every edge that lies a positive multiple
    // of (TC+1) edges after its last restart (reset or config write)
    longint k;
    longint m_start [NUM_CH];
    longint m_tc    [NUM_CH];
    bit     m_en    [NUM_CH];
    bit     m_mode  [NUM_CH];
    bit     m_tick  [NUM_CH];
    bit     m_wave  [NUM_CH];
    bit     m_req   [NUM_CH];
    bit     m_ovr   [NUM_CH];
    int     m_oc    [NUM_CH];

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%h exp=%h", tag, k, obs, exp);
        end
    endtask

    function automatic bit ticks_at(input int c, input longint edge_n);
        longint d;
        d = edge_n - m_start[c];
        return m_en[c] && (d > 0) && ((d % (m_tc[c] + 1)) == 0);
    endfunction

    task automatic model_edge();
        bit t;
        for (int c = 0; c < NUM_CH; c++) begin
            if (RESET) begin
                m_start[c] = k; m_tc[c] = DEF_TC; m_en[c] = 1'b1; m_mode[c] = 1'b1;
                m_tick[c] = 0; m_wave[c] = 0; m_req[c] = 0; m_ovr[c] = 0; m_oc[c] = 0;
            end else if (CFG_WE && int'(CFG_CH) == c) begin
                m_start[c] = k; m_tc[c] = longint'(CFG_TC); m_en[c] = CFG_EN; m_mode[c] = CFG_MODE;
                m_tick[c] = 0; m_wave[c] = 0; m_req[c] = 0; m_ovr[c] = 0; m_oc[c] = 0;
            end else begin
                t = ticks_at(c, k);
                if (t && m_req[c] && !ACK[c]) begin
                    m_ovr[c] = 1'b1;
                    if (m_oc[c] < (1 << OVR_W) - 1) m_oc[c]++;
                end
                if (t) m_req[c] = 1'b1;
                else if (ACK[c]) m_req[c] = 1'b0;
                m_tick[c] = t;
                if (m_en[c]) m_wave[c] = m_mode[c] ? (m_wave[c] ^ t) : t;
            end
        end
    endtask

    task automatic push_expected();
        logic [63:0] vt, vw, vr, vo, vc;
        vt = '0; vw = '0; vr = '0; vo = '0; vc = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            vt[c] = m_tick[c]; vw[c] = m_wave[c]; vr[c] = m_req[c]; vo[c] = m_ovr[c];
            vc[c*OVR_W +: OVR_W] = OVR_W'(m_oc[c]);
        end
        exp_q.push_back(vt); exp_q.push_back(vw); exp_q.push_back(vr);
        exp_q.push_back(vo); exp_q.push_back(vc);
    endtask

    // driver: one clock edge with the currently driven inputs, then check outputs
    task automatic step();
        logic [63:0] e_t, e_w, e_r, e_o, e_c;
        @(posedge CLK);
        k++;
        model_edge();
        push_expected();
        #1;
        e_t = exp_q.pop_front(); e_w = exp_q.pop_front(); e_r = exp_q.pop_front();
        e_o = exp_q.pop_front(); e_c = exp_q.pop_front();
        chk("tick", 64'(TICK), e_t);
        chk("wave", 64'(WAVE), e_w);
        chk("req", 64'(REQ), e_r);
        chk("overrun", 64'(OVERRUN), e_o);
`ifdef MULTI_TICK_OVR_CNT_EN
        chk("ovr_cnt", 64'(OVR_CNT), e_c);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg_write(input int ch, input int tc, input bit mode, input bit en);
        CFG_WE = 1'b1; CFG_CH = CH_W'(ch); CFG_TC = CNT_W'(tc); CFG_MODE = mode; CFG_EN = en;
        step();
        CFG_WE = 1'b0;
    endtask

    initial begin
        int budget;
        k = 0;
        RESET = 1'b1; CFG_WE = 1'b0; CFG_CH = '0; CFG_TC = '0; CFG_MODE = 1'b0; CFG_EN = 1'b0;
        ACK = '0;
        idle(2);
        RESET = 1'b0;

        // defaults: every channel toggles with period 2*(DEF_TC+1), ACK held low
        idle(2 * (DEF_TC + 1) + 3);

        // ch1 pulse TC=3
        cfg_write(1, 3, 1'b0, 1'b1);
        idle(14);

        // ch2 TC=2 with no ACK: request, then overruns
        cfg_write(2, 2, 1'b1, 1'b1);
        idle(10);

        // ch3 TC=4, ACK exactly on the wrap edges
        cfg_write(3, 4, 1'b0, 1'b1);
        for (int i = 0; i < 22; i++) begin
            ACK[3] = ticks_at(3, k + 1);
            step();
        end
        ACK = '0;

        // write ch1 on its own wrap edge
        budget = 0;
        while (!ticks_at(1, k + 1) && budget < 10) begin
            step();
            budget++;
        end
        chk("ch1_wrap_found", 64'(budget < 10), 64'd1);
        cfg_write(1, 3, 1'b0, 1'b1);
        idle(6);

        // out-of-range channel writes change nothing
        cfg_write(7, 0, 1'b0, 1'b0);
        cfg_write(5, 1, 1'b1, 1'b0);
        idle(4);

        // ch4 TC=0 with no ACK: tick every cycle, overrun count saturates
        cfg_write(4, 0, 1'b1, 1'b1);
        idle(262);

        // write coinciding with ACK on the same channel, then disable a channel
        ACK[2] = 1'b1;
        cfg_write(2, 5, 1'b1, 1'b1);
        ACK[2] = 1'b0;
        cfg_write(4, 2, 1'b1, 1'b0);
        ACK[4] = 1'b1;
        idle(3);
        ACK = '0;

        // reset mid-period with REQ and OVERRUN pending
        idle(5);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        idle(DEF_TC + 4);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            RESET  = ($urandom_range(0, 299) == 0);
            CFG_WE = ($urandom_range(0, 11) == 0);
            CFG_CH = CH_W'($urandom_range(0, 7));
            CFG_TC = CNT_W'($urandom_range(0, 6));
            CFG_MODE = 1'($urandom_range(0, 1));
            CFG_EN = ($urandom_range(0, 3) != 0);
            ACK    = NUM_CH'($urandom);
            step();
        end
        RESET = 1'b0; CFG_WE = 1'b0; ACK = '0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
